// File: rtl/ysyx_lsu_l1d.sv
// Load/store unit with a direct-mapped, write-through, no-write-allocate L1 data cache.
// Requests are held on the bus until accepted; results are returned as a one-cycle response pulse.
module ysyx_lsu_l1d #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int L1D_LEN = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 32'ha0000000,
  parameter logic [ADDR_W-1:0] MMIO_MASK = 32'hf0000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [2:0]          req_func,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic                flush,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   bus_araddr,
  output logic                bus_arvalid,
  input  logic                bus_arready,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_rvalid,
  output logic [ADDR_W-1:0]   bus_awaddr,
  output logic                bus_awvalid,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic                bus_wvalid,
  input  logic                bus_wready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int TAG_W  = ADDR_W - OFF_W - L1D_LEN;
  localparam int LINES  = 1 << L1D_LEN;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_t;

  state_t              state;
  logic                flush_pend;
  logic [LINES-1:0]    line_vld;
  logic [TAG_W-1:0]    line_tag  [LINES];
  logic [DATA_W-1:0]   line_data [LINES];
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          func_q;

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                 input logic [2:0] func,
                                                 input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] sh;
    sh = word >> {off, 3'b000};
    case (func)
      3'd0:    load_ext = DATA_W'($signed(sh[7:0]));
      3'd1:    load_ext = DATA_W'($signed(sh[15:0]));
      3'd2:    load_ext = DATA_W'($signed(sh[31:0]));
      3'd4:    load_ext = DATA_W'(sh[7:0]);
      3'd5:    load_ext = DATA_W'(sh[15:0]);
      3'd6:    load_ext = DATA_W'(sh[31:0]);
      default: load_ext = sh;
    endcase
  endfunction

  // Access size is encoded in func[1:0] for both signed and unsigned variants.
  function automatic logic [STRB_W-1:0] lane_mask(input logic [2:0] func);
    case (func[1:0])
      2'd0:    lane_mask = STRB_W'(1);
      2'd1:    lane_mask = STRB_W'(3);
      2'd2:    lane_mask = STRB_W'(15);
      default: lane_mask = '1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] func, input logic [OFF_W-1:0] off);
    case (func[1:0])
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = (off[1:0] != 2'd0);
      2'd3:    misaligned = (off != '0);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic cacheable(input logic [ADDR_W-1:0] addr);
    cacheable = ((addr & MMIO_MASK) != MMIO_BASE);
  endfunction

  logic [OFF_W-1:0]   req_off, q_off;
  logic [L1D_LEN-1:0] req_idx, q_idx;
  logic [TAG_W-1:0]   req_tag, q_tag;
  logic               req_bad, req_hit, q_hit, accept, fill_en, merge_en;

  assign req_off = req_addr[OFF_W-1:0];
  assign req_idx = req_addr[OFF_W+L1D_LEN-1:OFF_W];
  assign req_tag = req_addr[ADDR_W-1:OFF_W+L1D_LEN];
  assign q_off   = addr_q[OFF_W-1:0];
  assign q_idx   = addr_q[OFF_W+L1D_LEN-1:OFF_W];
  assign q_tag   = addr_q[ADDR_W-1:OFF_W+L1D_LEN];

  assign req_bad = misaligned(req_func, req_off) || (req_func == 3'd7) ||
                   ((DATA_W == 32) && ((req_func == 3'd3) || (req_func == 3'd6)));
  // A flush in the accept cycle wins over a hit on the line it is about to clear.
  assign req_hit = cacheable(req_addr) && line_vld[req_idx] &&
                   (line_tag[req_idx] == req_tag) && !flush;
  assign q_hit   = cacheable(addr_q) && line_vld[q_idx] && (line_tag[q_idx] == q_tag);

  assign req_ready = (state == IDLE) && !flush_pend;
  assign accept    = req_valid && req_ready;
  assign fill_en   = (state == RD_DATA) && bus_rvalid && cacheable(addr_q) && !flush_pend && !flush;
  assign merge_en  = (state == WR) && bus_wready && q_hit;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_data[q_idx] <= bus_rdata;
      line_tag[q_idx]  <= q_tag;
    end else if (merge_en) begin
      for (int b = 0; b < STRB_W; b++)
        if (bus_wstrb[b]) line_data[q_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      flush_pend  <= 1'b0;
      line_vld    <= '0;
      addr_q      <= '0;
      func_q      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      bus_araddr  <= '0;
      bus_arvalid <= 1'b0;
      bus_awaddr  <= '0;
      bus_awvalid <= 1'b0;
      bus_wdata   <= '0;
      bus_wstrb   <= '0;
      bus_wvalid  <= 1'b0;
    end else begin
      if (state == IDLE) flush_pend <= 1'b0;
      else if (flush)    flush_pend <= 1'b1;

      if ((state == IDLE) && (flush || flush_pend)) line_vld <= '0;
      else if (fill_en)                             line_vld[q_idx] <= 1'b1;

      case (state)
        IDLE: if (accept) begin
          addr_q <= req_addr;
          func_q <= req_func;
          if (req_bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (req_wen) begin
            state       <= WR;
            bus_awvalid <= 1'b1;
            bus_wvalid  <= 1'b1;
            bus_awaddr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wdata   <= req_wdata << {req_off, 3'b000};
            bus_wstrb   <= lane_mask(req_func) << req_off;
          end else if (req_hit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_ext(line_data[req_idx], req_func, req_off);
          end else begin
            state       <= RD_ADDR;
            bus_arvalid <= 1'b1;
            bus_araddr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        RD_ADDR: if (bus_arready) begin
          bus_arvalid <= 1'b0;
          state       <= RD_DATA;
        end
        RD_DATA: if (bus_rvalid) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= load_ext(bus_rdata, func_q, q_off);
        end
        WR: if (bus_wready) begin
          bus_awvalid <= 1'b0;
          bus_wvalid  <= 1'b0;
          state       <= RESP;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= '0;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_lsu_l1d.sv
// Directed bench for ysyx_lsu_l1d: cached/uncached loads, stores, lane handling,
// error responses, flush and mid-transaction reset, with a hand-driven bus.
module tb_ysyx_lsu_l1d;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, flush;
  logic [2:0]  req_func;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] bus_araddr, bus_awaddr, bus_rdata, bus_wdata;
  logic        bus_arvalid, bus_arready, bus_rvalid, bus_awvalid, bus_wvalid, bus_wready;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int failures = 0;

  ysyx_lsu_l1d dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_func(req_func),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wen, input logic [2:0] func, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n = 0;
    while (!req_ready && n < 8) begin step(); n++; end
    req_valid = 1'b1; req_wen = wen; req_func = func; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  task automatic serve_read(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    int n = 0;
    while (!bus_arvalid && n < 8) begin step(); n++; end
    check({tag, " arvalid"}, 64'(bus_arvalid), 64'(1));
    check({tag, " araddr"}, 64'(bus_araddr), 64'(exp_addr));
    bus_arready = 1'b1;
    step();
    bus_arready = 1'b0;
    check({tag, " arvalid drop"}, 64'(bus_arvalid), 64'(0));
    bus_rdata = data; bus_rvalid = 1'b1;
    step();
    bus_rvalid = 1'b0;
  endtask

  task automatic load_miss(input string tag, input logic [2:0] func, input logic [31:0] addr,
                           input logic [31:0] word, input logic [31:0] exp);
    issue(1'b0, func, addr, 32'h0);
    serve_read(tag, {addr[31:2], 2'b00}, word);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, " rdata"}, 64'(rsp_rdata), 64'(exp));
    step();
    check({tag, " rsp_valid pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  task automatic load_hit(input string tag, input logic [2:0] func, input logic [31:0] addr,
                          input logic [31:0] exp);
    issue(1'b0, func, addr, 32'h0);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, " arvalid"}, 64'(bus_arvalid), 64'(0));
    check({tag, " rdata"}, 64'(rsp_rdata), 64'(exp));
    step();
    check({tag, " rsp_valid pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  task automatic store(input string tag, input logic [2:0] func, input logic [31:0] addr,
                       input logic [31:0] wdata, input int wait_cyc,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    int cnt = 0;
    issue(1'b1, func, addr, wdata);
    check({tag, " awaddr"}, 64'(bus_awaddr), 64'({addr[31:2], 2'b00}));
    check({tag, " wstrb"}, 64'(bus_wstrb), 64'(exp_strb));
    check({tag, " wdata"}, 64'(bus_wdata), 64'(exp_wdata));
    check({tag, " wvalid"}, 64'(bus_wvalid), 64'(1));
    while (bus_awvalid && cnt < 20) begin
      cnt++;
      if (cnt == wait_cyc) bus_wready = 1'b1;
      step();
      bus_wready = 1'b0;
    end
    check({tag, " awvalid cycles"}, 64'(cnt), 64'(wait_cyc));
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, " rdata"}, 64'(rsp_rdata), 64'(0));
    step();
  endtask

  task automatic err_req(input string tag, input logic wen, input logic [2:0] func,
                         input logic [31:0] addr);
    issue(wen, func, addr, 32'h12345678);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, " rsp_err"}, 64'(rsp_err), 64'(1));
    check({tag, " bus idle"}, 64'({bus_arvalid, bus_awvalid, bus_wvalid}), 64'(0));
    step();
    check({tag, " rsp_valid pulse"}, 64'(rsp_valid), 64'(0));
    check({tag, " rsp_err clear"}, 64'(rsp_err), 64'(0));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func = 3'd0; req_addr = '0;
    req_wdata = '0; flush = 1'b0; bus_arready = 1'b0; bus_rdata = '0; bus_rvalid = 1'b0;
    bus_wready = 1'b0;
    step(); step();
    check("reset ready", 64'(req_ready), 64'(1));
    check("reset rsp", 64'({rsp_valid, rsp_err}), 64'(0));
    check("reset rdata", 64'(rsp_rdata), 64'(0));
    check("reset bus valids", 64'({bus_arvalid, bus_awvalid, bus_wvalid}), 64'(0));
    rst = 1'b0;
    step();

    // Store-through without allocate, then miss, then hit.
    store("sw1", 3'd2, 32'h80000010, 32'hdeadbeef, 3, 4'hf, 32'hdeadbeef);
    load_miss("lw1 miss", 3'd2, 32'h80000010, 32'hdeadbeef, 32'hdeadbeef);
    load_hit("lw1 hit", 3'd2, 32'h80000010, 32'hdeadbeef);

    // Lane selection and extension.
    load_miss("lb off1", 3'd0, 32'h80000021, 32'h8a7bffee, 32'hffffffff);
    load_hit("lbu off3", 3'd4, 32'h80000023, 32'h0000008a);
    load_hit("lh off2", 3'd1, 32'h80000022, 32'hffff8a7b);
    load_hit("lhu off0", 3'd5, 32'h80000020, 32'h0000ffee);

    // Byte store merges into a resident line.
    store("sb off3", 3'd0, 32'h80000023, 32'h00000055, 1, 4'b1000, 32'h55000000);
    load_hit("lw merged", 3'd2, 32'h80000020, 32'h557bffee);

    // Error responses.
    err_req("lw misaligned", 1'b0, 3'd2, 32'h80000002);
    err_req("sh misaligned", 1'b1, 3'd1, 32'h80000001);
    err_req("ld illegal", 1'b0, 3'd3, 32'h80000010);

    // Uncached window never hits.
    load_miss("mmio lw1", 3'd2, 32'ha0000000, 32'h11111111, 32'h11111111);
    load_miss("mmio lw2", 3'd2, 32'ha0000000, 32'h11111112, 32'h11111112);

    // Flush while busy: deferred to the return to IDLE.
    issue(1'b0, 3'd2, 32'ha0000004, 32'h0);
    check("flush arvalid", 64'(bus_arvalid), 64'(1));
    bus_arready = 1'b1; step(); bus_arready = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    bus_rdata = 32'h22222222; bus_rvalid = 1'b1; step(); bus_rvalid = 1'b0;
    check("flush rsp_valid", 64'(rsp_valid), 64'(1));
    check("flush rdata", 64'(rsp_rdata), 64'(32'h22222222));
    step();
    check("flush pend ready", 64'(req_ready), 64'(0));
    step();
    check("flush done ready", 64'(req_ready), 64'(1));
    load_miss("post-flush lw", 3'd2, 32'h80000010, 32'h12345678, 32'h12345678);

    // Reset during RD_DATA aborts silently and clears the cache.
    issue(1'b0, 3'd2, 32'h80000030, 32'h0);
    bus_arready = 1'b1; step(); bus_arready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst arvalid", 64'(bus_arvalid), 64'(0));
    check("rst rsp_valid", 64'(rsp_valid), 64'(0));
    rst = 1'b0;
    bus_rdata = 32'h33333333; bus_rvalid = 1'b1; step(); bus_rvalid = 1'b0;
    check("rst stray rvalid", 64'(rsp_valid), 64'(0));
    step();
    check("rst no rsp", 64'(rsp_valid), 64'(0));
    load_miss("rst reread", 3'd2, 32'h80000030, 32'h44444444, 32'h44444444);
    load_miss("rst cleared", 3'd2, 32'h80000010, 32'h55555555, 32'h55555555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
